// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO: circular buffer with registered flags,
// occupancy count, synchronous flush and one-cycle overflow/underflow pulses.
//
// Ports:
//   clk, rst (async, active-high), clr (sync flush)
//   wr_en/wr_data           : write request and data
//   rd_en                   : read request
//   rd_data/rd_valid        : registered read data, valid for one cycle
//   full/empty              : count == DEPTH / count == 0
//   almost_full/almost_empty: count >= AF_LEVEL / count <= AE_LEVEL
//   count                   : occupancy, $clog2(DEPTH+1) bits
//   overflow/underflow      : one-cycle pulse on a rejected write/read
module param_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              wr_ok;
    logic              rd_ok;

    // Wrap explicitly so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance uses the registered flags only: no same-cycle bypass.
    assign wr_ok = wr_en && !full && !clr;
    assign rd_ok = rd_en && !empty && !clr;

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok)
            count_nxt = count + CW'(1);
        else if (rd_ok && !wr_ok)
            count_nxt = count - CW'(1);
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            rd_valid  <= rd_ok;
            if (wr_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= ptr_inc(rd_ptr);
            end
            // Flags track the new count on the same edge.
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed, table-driven bench for param_fifo (DEPTH=8 instance plus
// a DEPTH=5 instance for pointer wrap-around).
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    logic        w5;
    logic [31:0] d5;
    logic        r5;
    logic [31:0] rd5;
    logic        rv5;
    logic        f5, e5, af5, ae5, ov5, uf5;
    logic [2:0]  c5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_fifo dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    param_fifo #(.DATA_W(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
        .clk(clk), .rst(rst), .clr(1'b0),
        .wr_en(w5), .wr_data(d5), .rd_en(r5),
        .rd_data(rd5), .rd_valid(rv5),
        .full(f5), .empty(e5),
        .almost_full(af5), .almost_empty(ae5),
        .count(c5), .overflow(ov5), .underflow(uf5)
    );

    typedef struct {
        logic        wr;
        logic [31:0] wd;
        logic        rd;
        logic        cl;
        int          cnt;
        logic        rdv;
        logic [31:0] rdd;
        logic [5:0]  fl;   // {full, empty, af, ae, ov, uf}
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic [31:0] wd,
                       input logic rd, input logic cl, input int cnt,
                       input logic rdv, input logic [31:0] rdd,
                       input logic [5:0] fl);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.cl = cl;
        v.cnt = cnt; v.rdv = rdv; v.rdd = rdd; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt,
                           input logic rdv, input logic [31:0] rdd,
                           input logic [5:0] fl);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(rdv));
        chk({tag, " rd_data"}, rd_data, rdd);
        chk({tag, " full"}, 32'(full), 32'(fl[5]));
        chk({tag, " empty"}, 32'(empty), 32'(fl[4]));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(fl[3]));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(fl[2]));
        chk({tag, " overflow"}, 32'(overflow), 32'(fl[1]));
        chk({tag, " underflow"}, 32'(underflow), 32'(fl[0]));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        w5 = 1'b0; r5 = 1'b0; d5 = '0;

        // Fill 0x11..0x88, then one rejected write.
        for (int k = 1; k <= 8; k++)
            add(1, 32'(32'h11 * k), 0, 0, k, 0, 0,
                (k == 8) ? 6'b101000 :
                (k >= 6) ? 6'b001000 :
                (k == 1) ? 6'b000100 : 6'b000000);
        add(1, 32'h99, 0, 0, 8, 0, 0, 6'b101010);
        add(0, 0, 0, 0, 8, 0, 0, 6'b101000);
        // Drain in order, then one rejected read.
        for (int k = 1; k <= 8; k++)
            add(0, 0, 1, 0, 8 - k, 1, 32'(32'h11 * k),
                (k == 8) ? 6'b010100 :
                (k == 7) ? 6'b000100 :
                (k <= 2) ? 6'b001000 : 6'b000000);
        add(0, 0, 1, 0, 0, 0, 32'h88, 6'b010101);
        // Both requests while empty: write wins, read rejected.
        add(1, 32'hA1, 1, 0, 1, 0, 32'h88, 6'b000101);
        add(0, 0, 0, 0, 1, 0, 32'h88, 6'b000100);
        for (int k = 2; k <= 8; k++)
            add(1, 32'(32'hA0 + k), 0, 0, k, 0, 32'h88,
                (k == 8) ? 6'b101000 :
                (k >= 6) ? 6'b001000 : 6'b000000);
        // Both requests while full: read wins, write rejected.
        add(1, 32'hB0, 1, 0, 7, 1, 32'hA1, 6'b001010);
        add(0, 0, 1, 0, 6, 1, 32'hA2, 6'b001000);
        add(0, 0, 1, 0, 5, 1, 32'hA3, 6'b000000);
        // Flush at count 5 with a concurrent write.
        add(1, 32'hCC, 0, 1, 0, 0, 32'h0, 6'b010100);
        add(0, 0, 0, 0, 0, 0, 32'h0, 6'b010100);

        tick();
        tick();
        chk_all("reset", 0, 0, 0, 6'b010100);
        chk("reset5 count", 32'(c5), 0);
        chk("reset5 empty", 32'(e5), 1);
        rst = 1'b0;
        tick();

        // Wrap-around on DEPTH=5 at steady count 3.
        for (int k = 0; k < 3; k++) begin
            w5 = 1'b1; d5 = 32'(k);
            tick();
            chk("wrap prime count", 32'(c5), 32'(k + 1));
        end
        for (int i = 0; i < 20; i++) begin
            w5 = 1'b1; r5 = 1'b1; d5 = 32'(i + 3);
            tick();
            chk("wrap count", 32'(c5), 3);
            chk("wrap rd_data", rd5, 32'(i));
            chk("wrap rd_valid", 32'(rv5), 1);
            chk("wrap flags", {28'd0, f5, e5, ov5, uf5}, 0);
        end
        w5 = 1'b0; r5 = 1'b0;

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr; wr_data = vecs[i].wd;
            rd_en = vecs[i].rd; clr = vecs[i].cl;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rdv,
                    vecs[i].rdd, vecs[i].fl);
        end
        idle_in();

        // Asynchronous reset mid-cycle at count 4.
        for (int k = 1; k <= 5; k++) begin
            wr_en = 1'b1; wr_data = 32'(k);
            tick();
            chk("pre-rst fill count", 32'(count), 32'(k));
        end
        idle_in();
        rd_en = 1'b1;
        tick();
        chk_all("pre-rst read", 4, 1, 32'h1, 6'b000000);
        idle_in();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_all("async rst", 0, 0, 0, 6'b010100);
        rst = 1'b0;
        wr_en = 1'b1; wr_data = 32'hAB;
        tick();
        chk_all("post-rst write", 1, 0, 0, 6'b000100);
        idle_in();
        rd_en = 1'b1;
        tick();
        chk_all("post-rst read", 0, 1, 32'hAB, 6'b010100);
        idle_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised synchronous FIFO and the successor to the fixed 7×32 shift-register FIFO. It is generalised in data width and depth. It uses a circular buffer with read and write pointers instead of shifting every entry. It adds the full, empty and almost flags, an occupancy count, a synchronous flush, and one-cycle overflow/underflow error pulses. It sits between a producer and a consumer in the same `clk` domain.

## Interface
Parameters:
- `DATA_W`, 32: data width in bits, ≥1.
- `DEPTH`, 8: number of entries, ≥2. It need not be a power of two.
- `AF_LEVEL`, 6: `almost_full` is high when `count >= AF_LEVEL`. Range 1..DEPTH.
- `AE_LEVEL`, 1: `almost_empty` is high when `count <= AE_LEVEL`. Range 0..DEPTH-1.

Ports (CW = $clog2(DEPTH+1)):
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous flush.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_W  write data.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  `rd_data` was loaded on the last edge.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  CW  occupancy.
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage is a DEPTH × DATA_W array with pointers `wr_ptr` and `rd_ptr`, each in 0..DEPTH-1.
  - A pointer at DEPTH-1 wraps to 0 on increment. This applies for any DEPTH.
  - The memory array itself is not reset.
- Acceptance is decided from the flags registered at the start of the cycle:
  - A write is accepted iff `wr_en && !full`.
  - A read is accepted iff `rd_en && !empty`.
  - No same-cycle bypass: a write into a full FIFO is rejected even if a read is accepted in the same cycle.
  - A read of an empty FIFO is rejected even if a write is accepted in the same cycle.
- Accepted write: `mem[wr_ptr] <= wr_data`, then `wr_ptr` advances.
- Accepted read: `rd_data <= mem[rd_ptr]`, `rd_ptr` advances, `rd_valid <= 1`.
- Otherwise `rd_valid <= 0` and `rd_data` holds its last value.
- Count update: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- Errors:
  - Rejected write: `overflow <= 1` for one cycle; FIFO state is unchanged.
  - Rejected read: `underflow <= 1` for one cycle; `rd_data` is unchanged.
- All flags are registered and updated on the same edge as `count`, so they always match `count`.
- Flush: `clr` has priority over `wr_en` and `rd_en`. When asserted:
  - pointers and count go to 0; flags go to their reset values;
  - `rd_valid`, `overflow`, `underflow` go to 0; `rd_data` goes to 0;
  - a write requested in the same cycle is dropped and no `overflow` is flagged.
- Reset (`rst` high, asynchronous, takes effect immediately and overrides everything):
  - pointers = 0, count = 0, `rd_data` = 0, `rd_valid` = 0;
  - `full` = 0, `empty` = 1, `almost_empty` = 1, `almost_full` = 0;
  - `overflow` = 0, `underflow` = 0.
- Reset mid-operation discards all contents. The first post-reset write lands at index 0.

## Timing
- Write-to-read latency:
  - A write accepted at edge N clears `empty` after edge N.
  - A read can be accepted at edge N+1, with data on `rd_data` and `rd_valid` high after edge N+1.
- Read latency: 1 cycle from the accepting edge to valid `rd_data`.
- `full` rises after the edge that accepts the DEPTH-th write. A read accepted at edge M clears it after edge M; a write can be accepted at edge M+1.
- Sustained throughput is one write and one read per cycle while 0 < count < DEPTH.
- `overflow` and `underflow` are high for exactly the cycle after the offending edge.
- Inputs are sampled at the rising edge. There are no combinational paths from inputs to outputs.

## Test plan
Defaults apply (DATA_W=32, DEPTH=8, AF=6, AE=1) unless a scenario says otherwise.
- Reset and fill:
  - Stimulus: release `rst`, then write 0x11..0x88 on 8 consecutive cycles.
  - Required: `count` steps 1..8; `almost_empty` clears at count 2; `almost_full` sets at count 6; `full` sets at count 8.
  - Then a 9th write of 0x99 → `overflow` pulses once; `count` stays 8.
- Drain in order:
  - Stimulus: from full, hold `rd_en` for 8 cycles.
  - Required: `rd_data` = 0x11..0x88 with `rd_valid` high each cycle; `empty` = 1 after the 8th read.
  - Then a 9th read → `underflow` pulses; `rd_data` holds 0x88; `rd_valid` = 0.
- Wrap-around:
  - Stimulus: with DEPTH=5, run 20 cycles of simultaneous read and write at count 3, writing an incrementing pattern.
  - Required: `count` stays 3 throughout; output data is in order with no loss across pointer wraps.
- Simultaneous requests at the boundaries:
  - When empty, assert `wr_en` and `rd_en` together → write accepted, `underflow` = 1, `count` = 1.
  - When full, assert both → read accepted, `overflow` = 1, `count` = 7.
- Flush and asynchronous reset:
  - At count 5, assert `clr` together with `wr_en` → `count` = 0, `empty` = 1, no `overflow`.
  - Assert `rst` mid-cycle at count 4 → all outputs reach their reset values before the next edge.
  - Then write 0xAB and read it back → `rd_data` = 0xAB.
